// File: rtl/barrett_stream_ctrl.sv
// Streaming front/back end for an external pipelined Barrett divider: issues items,
// tracks them through the fixed divider latency and buffers results in a credited FIFO.
module barrett_stream_ctrl #(
    parameter int M0LEN = 14,
    parameter int SHIFT = 27,
    parameter int LAT   = 4,
    parameter int DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*M0LEN-1:0]   in_dividend,
    input  logic [M0LEN-1:0]     in_m0,
    input  logic [SHIFT-1:0]     in_m0_inv,
    input  logic                 in_last,
    output logic [2*M0LEN-1:0]   bar_dividend,
    output logic [M0LEN-1:0]     bar_m0,
    output logic [SHIFT-1:0]     bar_m0_inverse,
    input  logic [M0LEN-1:0]     bar_quotient,
    input  logic [M0LEN-1:0]     bar_remainder,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [M0LEN-1:0]     out_quotient,
    output logic [M0LEN-1:0]     out_remainder,
    output logic                 out_last,
    output logic                 busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(DEPTH + LAT + 1);
    localparam int EW = 2 * M0LEN + 1;

    logic [LAT-1:0] vld_sr_r;
    logic [LAT-1:0] last_sr_r;
    logic [EW-1:0]  fifo_r [DEPTH];
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [CW-1:0]  count_r;

    logic           issue_s;
    logic           push_s;
    logic           pop_s;
    logic [SW-1:0]  inflight_s;
    logic [SW-1:0]  credit_s;
    logic [EW-1:0]  head_s;

    function automatic logic [SW-1:0] popcount(input logic [LAT-1:0] v);
        logic [SW-1:0] n;
        n = '0;
        for (int i = 0; i < LAT; i++) begin
            n = n + SW'(v[i]);
        end
        return n;
    endfunction

    // The divider samples these every edge; only issued cycles are tracked.
    assign bar_dividend   = in_dividend;
    assign bar_m0         = in_m0;
    assign bar_m0_inverse = in_m0_inv;

    assign issue_s = in_valid & in_ready;
    assign push_s  = vld_sr_r[LAT-1];
    assign pop_s   = out_valid & out_ready;

    // Credit and status, derived from registered state only (no path from in_valid/out_ready).
    always_comb begin
        inflight_s = popcount(vld_sr_r);
        credit_s   = SW'(count_r) + inflight_s;
        if (credit_s < SW'(DEPTH)) begin
            in_ready = 1'b1;
        end else begin
            in_ready = 1'b0;
        end
        out_valid = (count_r != '0);
        busy      = (inflight_s != '0) | (count_r != '0);
        head_s    = fifo_r[rd_ptr_r];
    end

    assign out_quotient  = head_s[EW-1 -: M0LEN];
    assign out_remainder = head_s[M0LEN:1];
    assign out_last      = head_s[0];

    // Valid/tag shift register mirroring the divider pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr_r  <= '0;
            last_sr_r <= '0;
        end else begin
            vld_sr_r  <= {vld_sr_r[LAT-2:0], issue_s};
            last_sr_r <= {last_sr_r[LAT-2:0], in_last};
        end
    end

    // Output FIFO: storage, wrapping pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_r[i] <= '0;
            end
        end else begin
            if (push_s) begin
                fifo_r[wr_ptr_r] <= {bar_quotient, bar_remainder, last_sr_r[LAT-1]};
                wr_ptr_r         <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_barrett_stream_ctrl.sv
// Bench for barrett_stream_ctrl: behavioural divider, queue-based reference model
// checked every cycle, plus directed tests with hand-computed results.
module tb_barrett_stream_ctrl;

    localparam int M0LEN = 14;
    localparam int SHIFT = 27;
    localparam int LAT   = 4;
    localparam int DEPTH = 8;
    localparam int NSOAK = 10000;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [2*M0LEN-1:0]   in_dividend;
    logic [M0LEN-1:0]     in_m0;
    logic [SHIFT-1:0]     in_m0_inv;
    logic                 in_last;
    logic [2*M0LEN-1:0]   bar_dividend;
    logic [M0LEN-1:0]     bar_m0;
    logic [SHIFT-1:0]     bar_m0_inverse;
    logic [M0LEN-1:0]     bar_quotient;
    logic [M0LEN-1:0]     bar_remainder;
    logic                 out_valid;
    logic                 out_ready;
    logic [M0LEN-1:0]     out_quotient;
    logic [M0LEN-1:0]     out_remainder;
    logic                 out_last;
    logic                 busy;

    logic ord;
    logic rnd_mode;
    logic rnd_bit;
    assign out_ready = rnd_mode ? rnd_bit : ord;

    int tests;
    int fails;

    barrett_stream_ctrl #(.M0LEN(M0LEN), .SHIFT(SHIFT), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dividend(in_dividend), .in_m0(in_m0), .in_m0_inv(in_m0_inv), .in_last(in_last),
        .bar_dividend(bar_dividend), .bar_m0(bar_m0), .bar_m0_inverse(bar_m0_inverse),
        .bar_quotient(bar_quotient), .bar_remainder(bar_remainder),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_quotient(out_quotient), .out_remainder(out_remainder), .out_last(out_last),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1 rnd_bit = 1'($urandom_range(1, 0));
    end

    // Behavioural divider: exact floor division, LAT register stages deep.
    logic [M0LEN-1:0] dq [LAT];
    logic [M0LEN-1:0] dr [LAT];
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) begin
            dq[i] <= dq[i-1];
            dr[i] <= dr[i-1];
        end
        if (bar_m0 != '0) begin
            dq[0] <= M0LEN'(bar_dividend / bar_m0);
            dr[0] <= M0LEN'(bar_dividend % bar_m0);
        end else begin
            dq[0] <= '0;
            dr[0] <= '0;
        end
    end
    assign bar_quotient  = dq[LAT-1];
    assign bar_remainder = dr[LAT-1];

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: every accepted item is outstanding until popped; the head
    // becomes visible LAT edges after its issue edge.
    typedef struct { int q; int r; int last; int rdy; } exp_t;
    typedef struct { int q; int r; int last; } got_t;
    exp_t mq[$];
    got_t got[$];
    int   cyc;

    initial begin
        bit   exp_v;
        bit   iss;
        bit   pop;
        got_t act;
        cyc = 0;
        forever begin
            @(negedge clk);
            exp_v = 1'b0;
            if (!rst_n) begin
                mq.delete();
                chk("rst_out_valid", out_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_in_ready", in_ready, 1);
                chk("rst_out_quotient", out_quotient, 0);
                chk("rst_out_remainder", out_remainder, 0);
                chk("rst_out_last", out_last, 0);
            end else begin
                exp_v = (mq.size() > 0) && (mq[0].rdy <= cyc);
                chk("out_valid", out_valid, exp_v);
                chk("in_ready", in_ready, mq.size() < DEPTH);
                chk("busy", busy, mq.size() != 0);
                chk("bar_wires", {bar_dividend, bar_m0, bar_m0_inverse} == {in_dividend, in_m0, in_m0_inv}, 1);
                if (exp_v) begin
                    chk("out_quotient", out_quotient, mq[0].q);
                    chk("out_remainder", out_remainder, mq[0].r);
                    chk("out_last", out_last, mq[0].last);
                    act = '{int'(out_quotient), int'(out_remainder), int'(out_last)};
                end
            end
            @(posedge clk);
            cyc++;
            if (rst_n) begin
                pop = exp_v && out_ready;
                iss = in_valid && (mq.size() < DEPTH);
                if (pop) begin
                    got.push_back(act);
                    void'(mq.pop_front());
                end
                if (iss) begin
                    mq.push_back('{int'(in_dividend / in_m0), int'(in_dividend % in_m0),
                                   int'(in_last), cyc + LAT});
                end
            end
        end
    end

    logic [2*M0LEN-1:0] it_d    [NSOAK];
    logic [M0LEN-1:0]   it_m    [NSOAK];
    logic               it_last [NSOAK];

    task automatic present(input int i);
        in_dividend = it_d[i];
        in_m0       = it_m[i];
        in_m0_inv   = SHIFT'((64'd1 << SHIFT) / it_m[i]);
        in_last     = it_last[i];
        in_valid    = 1'b1;
    endtask

    task automatic run_items(input int n, input int bub);
        bit r;
        int w;
        for (int i = 0; i < n; i++) begin
            while (bub > 0 && $urandom_range(99, 0) < bub) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            present(i);
            w = 0;
            do begin
                @(negedge clk);
                r = in_ready;
                @(posedge clk);
                #1;
                w++;
            end while (!r && w < 500);
            if (!r) begin
                chk("accept_timeout", 0, 1);
                i = n;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        @(negedge clk);
        while (busy && w < 2000) begin
            @(negedge clk);
            w++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic chk_got(input int i, input int q, input int r, input int last);
        if (i < got.size()) begin
            chk("lit_q", got[i].q, q);
            chk("lit_r", got[i].r, r);
            chk("lit_last", got[i].last, last);
        end else begin
            chk("lit_missing", got.size(), i + 1);
        end
    endtask

    initial begin
        #3_000_000;
        fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        int  n;
        int  idx;
        int  w;
        bit  r;
        logic [M0LEN-1:0] m;
        tests = 0; fails = 0;
        rst_n = 1'b0; ord = 1'b0; rnd_mode = 1'b0; rnd_bit = 1'b0;
        in_valid = 1'b0; in_dividend = '0; in_m0 = 14'd1; in_m0_inv = '0; in_last = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single item: latency and busy release.
        ord = 1'b1; got.delete();
        it_d[0] = 28'd1000000; it_m[0] = 14'd4591; it_last[0] = 1'b1;
        present(0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("single_latency", n, LAT);
        @(posedge clk);
        @(negedge clk);
        chk("single_busy_fall", busy, 0);
        chk_got(0, 217, 3753, 1);

        // Boundaries at m0=4591, back to back.
        got.delete();
        it_d[0] = 28'd4590; it_d[1] = 28'd4591; it_d[2] = 28'd0;
        for (int i = 0; i < 3; i++) begin
            it_m[i] = 14'd4591; it_last[i] = (i == 2);
        end
        @(posedge clk); #1;
        run_items(3, 0);
        wait_idle();
        chk_got(0, 0, 4590, 0);
        chk_got(1, 1, 0, 0);
        chk_got(2, 0, 0, 1);

        // Mixed moduli alternating per item.
        got.delete();
        for (int i = 0; i < 4; i++) begin
            it_d[i] = 28'd100000;
            it_m[i] = (i % 2 == 0) ? 14'd4591 : 14'd1531;
            it_last[i] = (i == 3);
        end
        @(posedge clk); #1;
        run_items(4, 0);
        wait_idle();
        chk_got(0, 21, 3589, 0);
        chk_got(1, 65, 485, 0);
        chk_got(2, 21, 3589, 0);
        chk_got(3, 65, 485, 1);

        // Backpressure: 20 items offered with the consumer stalled.
        got.delete(); ord = 1'b0;
        for (int i = 0; i < 20; i++) begin
            it_d[i] = 28'(4591 * i + i); it_m[i] = 14'd4591; it_last[i] = (i == 19);
        end
        @(posedge clk); #1;
        idx = 0;
        repeat (30) begin
            present(idx);
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            if (r) idx++;
        end
        chk("bp_accepted", idx, DEPTH);
        @(negedge clk);
        chk("bp_in_ready_low", in_ready, 0);
        @(posedge clk); #1;
        ord = 1'b1;
        w = 0;
        while (idx < 20 && w < 300) begin
            present(idx);
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            if (r) idx++;
            w++;
        end
        in_valid = 1'b0;
        chk("bp_all_accepted", idx, 20);
        wait_idle();
        chk("bp_drained", got.size(), 20);
        for (int i = 0; i < 20; i++) begin
            chk_got(i, i, i, (i == 19) ? 1 : 0);
        end

        // Reset with 2 buffered and 3 in flight.
        got.delete(); ord = 1'b0;
        for (int i = 0; i < 3; i++) begin
            it_d[i] = 28'(777 + i); it_m[i] = 14'd1531; it_last[i] = 1'b1;
        end
        @(posedge clk); #1;
        run_items(2, 0);
        repeat (LAT + 2) @(posedge clk);
        #1;
        run_items(3, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ord = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("mid_rst_no_stale", got.size(), 0);

        // Random soak with random consumer readiness.
        got.delete();
        for (int i = 0; i < NSOAK; i++) begin
            m = 14'($urandom_range(16383, 2));
            it_m[i] = m;
            it_d[i] = 28'($urandom % (32'(m) << M0LEN));
            it_last[i] = 1'($urandom_range(1, 0));
        end
        rnd_mode = 1'b1;
        run_items(NSOAK, 20);
        wait_idle();
        rnd_mode = 1'b0;
        chk("soak_count", got.size(), NSOAK);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
